// File: rtl/log_div_pkg.sv
// log_div_pkg: shared widths and pipeline stage records for log_div_pipe
package log_div_pkg;
  localparam int OP_W = 16;
  localparam int MANT_W = 15;
  localparam int EXP_W = 5;
  typedef struct packed {
    logic [3:0]        ka;
    logic [3:0]        kb;
    logic [MANT_W-1:0] xa;
    logic [MANT_W-1:0] xb;
    logic              za;
    logic              zb;
  } s1_t;
  typedef struct packed {
    logic [MANT_W:0]  mant;
    logic [EXP_W-1:0] exp;
    logic             za;
    logic             zb;
  } s2_t;
endpackage

// File: rtl/log_div_lod.sv
// log_div_lod: leading-one detector and normaliser giving characteristic k and 0.15 mantissa x
module log_div_lod
  import log_div_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  output logic [3:0]        k,
  output logic [MANT_W-1:0] x
);
  always_comb begin
    k = '0;
    for (int i = 0; i < OP_W; i++) if (a[i]) k = 4'(i);
    x = MANT_W'(a << (4'd15 - k));
  end
endmodule

// File: rtl/log_div_pipe.sv
// log_div_pipe: 3-stage Mitchell log divider with valid/ready handshake
// Define LOG_DIV_ROUND_EN to round half up on the antilog right shift instead of truncating.
module log_div_pipe
  import log_div_pkg::*;
#(
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      dividend,
  input  logic [OP_W-1:0]      divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_W+FRAC-1:0] quotient,
  output logic                 div_by_zero
);
  localparam int QW = OP_W + FRAC;
  s1_t s1, s1_d;
  s2_t s2, s2_d;
  logic s1_v, s2_v, en1, en2, en3;
  logic [3:0] ka, kb;
  logic [MANT_W-1:0] xa, xb;
  logic [OP_W-1:0] d;
  logic [6:0] amt;
  logic [63:0] big;
  logic [QW-1:0] q_d;
  assign en3 = !out_valid || out_ready;
  assign en2 = !s2_v || en3;
  assign en1 = !s1_v || en2;
  assign in_ready = en1;
  log_div_lod u_lod_a (.a(dividend), .k(ka), .x(xa));
  log_div_lod u_lod_b (.a(divisor), .k(kb), .x(xb));
  assign s1_d = '{ka: ka, kb: kb, xa: xa, xb: xb, za: dividend == '0, zb: divisor == '0};
  // a negative mantissa difference borrows one octave: 1+d becomes 2+d with exp-1, same low bits
  assign d = {1'b0, s1.xa} - {1'b0, s1.xb};
  assign s2_d = '{mant: {1'b1, d[MANT_W-1:0]},
                  exp: EXP_W'({1'b0, s1.ka}) - EXP_W'({1'b0, s1.kb}) - EXP_W'(d[OP_W-1]),
                  za: s1.za, zb: s1.zb};
  // mant sits at 2^32 in big so every net shift (exp+FRAC-15) becomes one right shift by amt
  always_comb begin
    amt = 7'(47 - FRAC) - {{2{s2.exp[EXP_W-1]}}, s2.exp};
`ifdef LOG_DIV_ROUND_EN
    big = ({16'b0, s2.mant, 32'b0} + (64'd1 << (amt - 7'd1))) >> amt;
`else
    big = {16'b0, s2.mant, 32'b0} >> amt;
`endif
    q_d = s2.zb ? '1 : s2.za ? '0 : (|big[63:QW]) ? '1 : big[QW-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      out_valid <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      quotient <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (en1) s1_v <= in_valid;
      if (en1 && in_valid) s1 <= s1_d;
      if (en2) s2_v <= s1_v;
      if (en2 && s1_v) s2 <= s2_d;
      if (en3) out_valid <= s2_v;
      if (en3 && s2_v) begin
        quotient <= q_d;
        div_by_zero <= s2.zb;
      end
    end
  end
endmodule
